or1k_intr_ctrl: RTL and testbench
=================================

# or1k_intr_ctrl

Interrupt front-end for the control group. It holds the programmable interrupt controller registers PICMR and PICSR for the 32 external interrupt lines, and watches the tick-timer pending bit on `spr_ttmr_i[28]`. It raises a single request to the exception unit and tags it as tick-timer or external. The request is held until the exception unit acknowledges it, then stays disarmed until software clears the source that was serviced.

## Interface
Parameters:
- `OPTION_PIC_TRIGGER`, default "LEVEL"; legal values "LEVEL", "EDGE", "LATCHED_LEVEL". Selects how PICSR is built.
- `OPTION_PIC_NMI_WIDTH`, default 0; range 0..32. Lines `[NMI_WIDTH-1:0]` are non-maskable: their PICMR bits read as 1 and cannot be written.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `irq_i` input 32: external interrupt lines, already synchronous to `clk`.
- `spr_ttmr_i` input 32: TTMR from the tick timer. Bit 29 = interrupt enable (IE), bit 28 = interrupt pending (IP).
- `supv_iee_i` input 1: SR[IEE], external interrupt enable.
- `supv_tee_i` input 1: SR[TEE], tick-timer exception enable.
- `spr_access_i` input 1: SPR group-9 access strobe.
- `spr_we_i` input 1: SPR write.
- `spr_addr_i` input 16: SPR address. Offset `[10:0]` 0 = PICMR, 2 = PICSR.
- `spr_dat_i` input 32: SPR write data.
- `spr_bus_ack` output 1: equals `spr_access_i` (combinational).
- `spr_dat_o` output 32: read data. 0 for any other offset and when there is no access.
- `spr_picmr_o` output 32: current PICMR.
- `spr_picsr_o` output 32: current PICSR.
- `irq_req_o` output 1: interrupt request to the exception unit.
- `irq_kind_o` output 1: 0 = tick timer, 1 = external. Valid while `irq_req_o` is high.
- `irq_ack_i` input 1: exception unit accepts the request.

## Operation
Reset values:
- PICMR = `{32-NMI_WIDTH zeros, NMI_WIDTH ones}`.
- PICSR = 0; the edge-detect history register = 0.
- FSM in IDLE.
- `irq_req_o` = 0, `irq_kind_o` = 0.

PICMR:
- Written when `spr_access_i & spr_we_i & offset==0`.
- NMI bits are forced to 1 regardless of the write data.

PICSR, by `OPTION_PIC_TRIGGER`:
- LEVEL: `picsr <= irq_i & picmr` every cycle. SPR writes are ignored.
- EDGE: bit set on a rising edge of `irq_i & picmr` (current value vs. registered previous value). Writing a 1 to a bit clears it. If set and clear coincide, set wins.
- LATCHED_LEVEL: bit set while `irq_i & picmr` is high. Writing a 1 clears it. Set wins.

Pending conditions:
- `tt_pend = supv_tee_i & spr_ttmr_i[29] & spr_ttmr_i[28]`.
- `ext_pend = supv_iee_i & |(picsr & picmr)`.

FSM (registered state):
- IDLE:
  - `tt_pend` → REQ with kind=0.
  - else `ext_pend` → REQ with kind=1.
  - The tick timer has priority over external interrupts.
- REQ:
  - `irq_req_o`=1 and `irq_kind_o` is held stable.
  - `irq_ack_i` → WAIT_CLR.
  - else if the pending condition for the latched kind drops → IDLE; the request is withdrawn. Ack wins if both happen in the same cycle.
- WAIT_CLR:
  - `irq_req_o`=0.
  - Leave for IDLE when the serviced source clears: kind 0 when `spr_ttmr_i[28]==0`; kind 1 when `(picsr & picmr)==0`.
  - Other sources are not considered until the FSM is back in IDLE.

Ack behaviour:
- `irq_ack_i` outside REQ is ignored.
- Reset in any state returns to IDLE on the next edge, and `irq_req_o` is 0 from that edge.

## Timing
- SPR reads are combinational from the current registers. A write is visible on `spr_dat_o` the cycle after the write.
- Interrupt path latency:
  - LEVEL/LATCHED_LEVEL: `irq_i` high before edge N → PICSR bit set at edge N → `irq_req_o` high from edge N+1.
  - EDGE: same latency as LEVEL; the edge is detected at edge N.
  - Tick timer: `spr_ttmr_i[28]` high before edge N → REQ entered at edge N → `irq_req_o` high from edge N.
- `irq_req_o` and `irq_kind_o` come directly from registers (no combinational input path).
- Ack sampled at edge M in REQ: `irq_req_o` low from edge M. Minimum one WAIT_CLR cycle before a new request.
- If a PICSR write-1 clear and a PICMR write happen back to back, each takes effect at its own edge. There are no hazards between them.

## Test plan
- Reset with NMI_WIDTH=2: PICMR reads 0x00000003, PICSR reads 0x0, `irq_req_o`=0. Write PICMR=0 → reads 0x00000003.
- LEVEL mode:
  - Set PICMR=0x10, IEE=1, `irq_i`=0x10 → PICSR=0x10 after one edge, `irq_req_o`=1 and kind=1 on the next edge.
  - Ack → req drops.
  - FSM stays in WAIT_CLR until `irq_i`=0, then returns to IDLE.
- EDGE mode: pulse `irq_i[3]` for one cycle with PICMR=0x8 → PICSR=0x8 stays set.
  - Write PICSR=0x8 in the same cycle as a new rising edge → PICSR stays 0x8.
  - Write again with no edge → PICSR=0.
- Priority: TTMR=0x3000_0000 (IE=1, IP=1), TEE=IEE=1, PICSR=0x1 with PICMR=0x1 → first request has kind=0.
  - Ack, then clear TTMR[28] → back to IDLE, then a new request with kind=1.
- Withdraw: in REQ with kind=1, drop IEE before ack → `irq_req_o`=0 the next edge and the FSM is in IDLE.
  - `irq_ack_i` pulsed in IDLE → no state change.
- Reset mid-request: assert `rst` while in REQ → `irq_req_o`=0 at the next edge, all registers return to reset values, SPR reads return the reset values.

Source files
------------

// File: rtl/or1k_intr_ctrl.sv
// rtl/or1k_intr_ctrl.sv - PIC registers and single-request interrupt front-end
module or1k_intr_ctrl #(
    parameter string OPTION_PIC_TRIGGER   = "LEVEL",
    parameter int    OPTION_PIC_NMI_WIDTH = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] irq_i,
    input  logic [31:0] spr_ttmr_i,
    input  logic        supv_iee_i,
    input  logic        supv_tee_i,
    input  logic        spr_access_i,
    input  logic        spr_we_i,
    input  logic [15:0] spr_addr_i,
    input  logic [31:0] spr_dat_i,
    output logic        spr_bus_ack,
    output logic [31:0] spr_dat_o,
    output logic [31:0] spr_picmr_o,
    output logic [31:0] spr_picsr_o,
    output logic        irq_req_o,
    output logic        irq_kind_o,
    input  logic        irq_ack_i
);

    // Non-maskable lines occupy the low bits; they always read as enabled.
    localparam logic [32:0] NMI_FULL = (33'd1 << OPTION_PIC_NMI_WIDTH) - 33'd1;
    localparam logic [31:0] NMI_MASK = NMI_FULL[31:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_CLR
    } state_t;

    logic [31:0] picmr;
    logic [31:0] picsr;
    logic [31:0] irq_masked;
    logic [10:0] offset;
    logic        picmr_we;
    logic        picsr_we;
    logic        tt_pend;
    logic        ext_pend;
    logic        ext_active;
    state_t      state;
    state_t      state_n;
    logic        irq_req_q;
    logic        irq_kind_q;
    logic        kind_n;
    logic        unused_bits;

    assign offset      = spr_addr_i[10:0];
    assign picmr_we    = spr_access_i & spr_we_i & (offset == 11'd0);
    assign picsr_we    = spr_access_i & spr_we_i & (offset == 11'd2);
    assign irq_masked  = irq_i & picmr;
    assign ext_active  = |(picsr & picmr);
    assign tt_pend     = supv_tee_i & spr_ttmr_i[29] & spr_ttmr_i[28];
    assign ext_pend    = supv_iee_i & ext_active;
    assign unused_bits = ^{spr_addr_i[15:11], spr_ttmr_i[31:30], spr_ttmr_i[27:0], picsr_we};

    assign spr_bus_ack = spr_access_i;
    assign spr_picmr_o = picmr;
    assign spr_picsr_o = picsr;
    assign irq_req_o   = irq_req_q;
    assign irq_kind_o  = irq_kind_q;

    // PICMR: software mask, NMI bits pinned high
    always_ff @(posedge clk) begin
        if (rst)
            picmr <= NMI_MASK;
        else if (picmr_we)
            picmr <= spr_dat_i | NMI_MASK;
    end

    generate
        if (OPTION_PIC_TRIGGER == "EDGE") begin : g_edge
            logic [31:0] irq_prev;
            logic [31:0] picsr_clr;
            assign picsr_clr = picsr_we ? spr_dat_i : 32'd0;
            // PICSR: latch rising edges of masked lines; write-1 clears, set wins
            always_ff @(posedge clk) begin
                if (rst) begin
                    irq_prev <= 32'd0;
                    picsr    <= 32'd0;
                end else begin
                    irq_prev <= irq_masked;
                    picsr    <= (picsr & ~picsr_clr) | (irq_masked & ~irq_prev);
                end
            end
        end else if (OPTION_PIC_TRIGGER == "LATCHED_LEVEL") begin : g_latched
            logic [31:0] picsr_clr;
            assign picsr_clr = picsr_we ? spr_dat_i : 32'd0;
            // PICSR: sticky while the masked line is high; write-1 clears, set wins
            always_ff @(posedge clk) begin
                if (rst)
                    picsr <= 32'd0;
                else
                    picsr <= (picsr & ~picsr_clr) | irq_masked;
            end
        end else begin : g_level
            // PICSR: follows the masked lines; software writes have no effect
            always_ff @(posedge clk) begin
                if (rst)
                    picsr <= 32'd0;
                else
                    picsr <= irq_masked;
            end
        end
    endgenerate

    // SPR read mux, zero when not addressed
    always_comb begin
        spr_dat_o = 32'd0;
        if (spr_access_i) begin
            case (offset)
                11'd0:   spr_dat_o = picmr;
                11'd2:   spr_dat_o = picsr;
                default: spr_dat_o = 32'd0;
            endcase
        end
    end

    // Request FSM next state: tick timer outranks external lines
    always_comb begin
        state_n = state;
        kind_n  = irq_kind_q;
        case (state)
            ST_IDLE: begin
                if (tt_pend) begin
                    state_n = ST_REQ;
                    kind_n  = 1'b0;
                end else if (ext_pend) begin
                    state_n = ST_REQ;
                    kind_n  = 1'b1;
                end
            end
            ST_REQ: begin
                if (irq_ack_i)
                    state_n = ST_WAIT_CLR;
                else if (irq_kind_q ? !ext_pend : !tt_pend)
                    state_n = ST_IDLE;
            end
            ST_WAIT_CLR: begin
                if (irq_kind_q ? !ext_active : !spr_ttmr_i[28])
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Request FSM state and registered request outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            irq_req_q  <= 1'b0;
            irq_kind_q <= 1'b0;
        end else begin
            state      <= state_n;
            irq_req_q  <= (state_n == ST_REQ);
            irq_kind_q <= kind_n;
        end
    end

endmodule

// File: tb/tb_or1k_intr_ctrl.sv
// tb/tb_or1k_intr_ctrl.sv - directed-vector bench for or1k_intr_ctrl
module tb_or1k_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] irq_i;
    logic [31:0] spr_ttmr_i;
    logic        supv_iee_i;
    logic        supv_tee_i;
    logic        spr_access_i;
    logic        spr_we_i;
    logic [15:0] spr_addr_i;
    logic [31:0] spr_dat_i;
    logic        irq_ack_i;

    logic        l_ack, e_ack;
    logic [31:0] l_dat, e_dat, l_picmr, e_picmr, l_picsr, e_picsr;
    logic        l_req, e_req, l_kind, e_kind;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    or1k_intr_ctrl #(.OPTION_PIC_TRIGGER("LEVEL"), .OPTION_PIC_NMI_WIDTH(2)) u_lvl (
        .clk(clk), .rst(rst), .irq_i(irq_i), .spr_ttmr_i(spr_ttmr_i),
        .supv_iee_i(supv_iee_i), .supv_tee_i(supv_tee_i),
        .spr_access_i(spr_access_i), .spr_we_i(spr_we_i), .spr_addr_i(spr_addr_i),
        .spr_dat_i(spr_dat_i), .spr_bus_ack(l_ack), .spr_dat_o(l_dat),
        .spr_picmr_o(l_picmr), .spr_picsr_o(l_picsr),
        .irq_req_o(l_req), .irq_kind_o(l_kind), .irq_ack_i(irq_ack_i)
    );

    or1k_intr_ctrl #(.OPTION_PIC_TRIGGER("EDGE"), .OPTION_PIC_NMI_WIDTH(0)) u_edg (
        .clk(clk), .rst(rst), .irq_i(irq_i), .spr_ttmr_i(spr_ttmr_i),
        .supv_iee_i(supv_iee_i), .supv_tee_i(supv_tee_i),
        .spr_access_i(spr_access_i), .spr_we_i(spr_we_i), .spr_addr_i(spr_addr_i),
        .spr_dat_i(spr_dat_i), .spr_bus_ack(e_ack), .spr_dat_o(e_dat),
        .spr_picmr_o(e_picmr), .spr_picsr_o(e_picsr),
        .irq_req_o(e_req), .irq_kind_o(e_kind), .irq_ack_i(irq_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic spr_write(input logic [10:0] off, input logic [31:0] dat);
        spr_access_i = 1'b1;
        spr_we_i     = 1'b1;
        spr_addr_i   = {5'd0, off};
        spr_dat_i    = dat;
        step();
        spr_access_i = 1'b0;
        spr_we_i     = 1'b0;
        spr_dat_i    = 32'd0;
    endtask

    task automatic spr_read(input logic [10:0] off, output logic [31:0] l_val, output logic [31:0] e_val);
        spr_access_i = 1'b1;
        spr_addr_i   = {5'd0, off};
        #1;
        l_val = l_dat;
        e_val = e_dat;
        spr_access_i = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [31:0] rl, re;

    initial begin
        rst = 1'b1; irq_i = '0; spr_ttmr_i = '0; supv_iee_i = 0; supv_tee_i = 0;
        spr_access_i = 0; spr_we_i = 0; spr_addr_i = '0; spr_dat_i = '0; irq_ack_i = 0;
        step();
        step();
        rst = 1'b0;

        // reset state
        spr_read(11'd0, rl, re);
        check("rst_picmr_nmi2", rl, 32'h3);
        check("rst_picmr_nmi0", re, 32'h0);
        spr_read(11'd2, rl, re);
        check("rst_picsr", rl, 32'h0);
        check("rst_req", {31'd0, l_req}, 32'd0);
        check("rst_kind", {31'd0, l_kind}, 32'd0);
        check("no_access_dat", l_dat, 32'h0);
        spr_access_i = 1'b1; spr_addr_i = 16'd0; #1;
        check("bus_ack", {31'd0, l_ack}, 32'd1);
        spr_access_i = 1'b0; #1;
        spr_write(11'd0, 32'h0);
        spr_read(11'd0, rl, re);
        check("nmi_write0", rl, 32'h3);

        // LEVEL: mask line 4, raise it
        spr_write(11'd0, 32'h10);
        supv_iee_i = 1'b1;
        irq_i = 32'h10;
        step();
        check("lvl_picsr_set", l_picsr, 32'h10);
        check("lvl_req_not_yet", {31'd0, l_req}, 32'd0);
        step();
        check("lvl_req", {31'd0, l_req}, 32'd1);
        check("lvl_kind", {31'd0, l_kind}, 32'd1);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("lvl_ack_drop", {31'd0, l_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lvl_wait_clr", {31'd0, l_req}, 32'd0);
        end
        irq_i = 32'h0;
        step();
        step();
        irq_i = 32'h10;
        step();
        check("lvl_rearm_pending", {31'd0, l_req}, 32'd0);
        step();
        check("lvl_rearm_req", {31'd0, l_req}, 32'd1);
        irq_i = 32'h0; supv_iee_i = 1'b0;
        do_reset();

        // EDGE: one-cycle pulse on line 3 stays latched
        spr_write(11'd0, 32'h8);
        irq_i = 32'h8;
        step();
        irq_i = 32'h0;
        check("edg_set", e_picsr, 32'h8);
        step();
        check("edg_hold1", e_picsr, 32'h8);
        step();
        check("edg_hold2", e_picsr, 32'h8);
        irq_i = 32'h8;
        spr_write(11'd2, 32'h8);
        check("edg_set_wins", e_picsr, 32'h8);
        check("lvl_ignores_wr", l_picsr, 32'h8);
        spr_write(11'd2, 32'h8);
        check("edg_clear", e_picsr, 32'h0);
        spr_read(11'd2, rl, re);
        check("edg_clear_read", re, 32'h0);
        irq_i = 32'h0;
        do_reset();

        // priority: tick timer before external
        spr_write(11'd0, 32'h1);
        spr_ttmr_i = 32'h3000_0000;
        supv_tee_i = 1'b1;
        supv_iee_i = 1'b1;
        irq_i = 32'h1;
        step();
        check("pri_tt_req", {31'd0, l_req}, 32'd1);
        check("pri_tt_kind", {31'd0, l_kind}, 32'd0);
        check("pri_picsr", l_picsr, 32'h1);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("pri_ack_drop", {31'd0, l_req}, 32'd0);
        step();
        check("pri_tt_wait", {31'd0, l_req}, 32'd0);
        spr_ttmr_i = 32'h2000_0000;
        step();
        check("pri_back_idle", {31'd0, l_req}, 32'd0);
        step();
        check("pri_ext_req", {31'd0, l_req}, 32'd1);
        check("pri_ext_kind", {31'd0, l_kind}, 32'd1);

        // withdraw by dropping IEE, then ack in IDLE is ignored
        supv_iee_i = 1'b0;
        step();
        check("wd_req_drop", {31'd0, l_req}, 32'd0);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("wd_idle_ack", {31'd0, l_req}, 32'd0);
        supv_iee_i = 1'b1;
        step();
        check("wd_rereq", {31'd0, l_req}, 32'd1);
        check("wd_rereq_kind", {31'd0, l_kind}, 32'd1);

        // reset while requesting
        rst = 1'b1;
        step();
        check("mid_rst_req", {31'd0, l_req}, 32'd0);
        check("mid_rst_kind", {31'd0, l_kind}, 32'd0);
        check("mid_rst_picmr", l_picmr, 32'h3);
        check("mid_rst_picsr", l_picsr, 32'h0);
        rst = 1'b0;
        irq_i = 32'h0; supv_iee_i = 1'b0; supv_tee_i = 1'b0; spr_ttmr_i = 32'h0;
        spr_read(11'd0, rl, re);
        check("mid_rst_rd_picmr", rl, 32'h3);
        spr_read(11'd2, rl, re);
        check("mid_rst_rd_picsr", rl, 32'h0);
        step();
        check("mid_rst_idle", {31'd0, l_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
